// File: rtl/suma_multipalabra_ctrl.sv
// ----------------------------------------------------------------------------
// suma_multipalabra_ctrl
//
// Multi-word add/subtract sequencer. A wide W = M*K bit operation is carried
// out by one shared M-bit slice adder over K cycles. The carry between slices
// is held in a register, and slices are processed from LSB to MSB. Operands
// are taken in through a start valid/ready handshake. The wide result and its
// C/N/V/Z flags are handed out through a result valid/ready handshake.
//
// Parameters:
//   M            slice width (width of the shared adder), default 4
//   K            number of slices, default 4; W = M*K
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   start_valid  A/B/op_sub are valid
//   start_ready  block is idle and can accept an operation
//   A, B         W-bit operands, sampled on accept
//   op_sub       0 = A+B, 1 = A-B, sampled on accept
//   res_valid    R and flags are valid
//   res_ready    consumer takes the result
//   R            W-bit result
//   C            carry out of bit W-1 (for subtract, 1 = no borrow)
//   N            R[W-1]
//   V            signed two's-complement overflow
//   Z            R == 0
//   busy         operation in progress or result pending
//
// Build option:
//   SUMA_CTRL_SAT_EN  when defined, a signed overflow on the last slice
//                     replaces R with the signed saturation value. V still
//                     reports the overflow and C still reports the raw carry.
//                     N and Z follow the saturated R.
// ----------------------------------------------------------------------------
module suma_multipalabra_ctrl #(
   parameter int M = 4,
   parameter int K = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [M*K-1:0]   A,
   input  logic [M*K-1:0]   B,
   input  logic             op_sub,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [M*K-1:0]   R,
   output logic             C,
   output logic             N,
   output logic             V,
   output logic             Z,
   output logic             busy
);

   localparam int W  = M * K;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

   logic [1:0]    state;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [W-1:0]  r_reg;
   logic          cin;
   logic [CW-1:0] cnt;
   logic          c_q, n_q, v_q, z_q;

   // Slice datapath
   logic          last;
   logic [CW-1:0] idx;
   logic [31:0]   base;
   logic [M-1:0]  a_sl;
   logic [M-1:0]  b_sl;
   logic [M:0]    sum;
   logic [W-1:0]  r_slice;
   logic [W-1:0]  r_fin;
   logic          v_fin;
   logic          n_fin;
   logic          z_fin;

   always_comb begin
      // Counter values past K-1 cannot be reached. They are still treated as
      // the last slice and clamped to it, so that no select goes out of range.
      last    = (cnt >= LAST_IDX);
      idx     = last ? LAST_IDX : cnt;
      base    = 32'(idx) * 32'(M);
      a_sl    = a_reg[base +: M];
      b_sl    = b_reg[base +: M];
      sum     = {1'b0, a_sl} + {1'b0, b_sl} + {{M{1'b0}}, cin};
      r_slice = r_reg;
      r_slice[base +: M] = sum[M-1:0];

      // b_reg already holds ~B for subtract, so the overflow test is the
      // plain addition form.
      v_fin   = (a_reg[W-1] == b_reg[W-1]) && (sum[M-1] != a_reg[W-1]);
`ifdef SUMA_CTRL_SAT_EN
      r_fin   = r_slice;
      if (v_fin) begin
         r_fin = a_reg[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
      n_fin   = r_fin[W-1];
`else
      r_fin   = r_slice;
      n_fin   = sum[M-1];
`endif
      z_fin   = (r_fin == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         a_reg <= '0;
         b_reg <= '0;
         r_reg <= '0;
         cin   <= 1'b0;
         cnt   <= '0;
         c_q   <= 1'b0;
         n_q   <= 1'b0;
         v_q   <= 1'b0;
         z_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_valid) begin
                  a_reg <= A;
                  b_reg <= op_sub ? ~B : B;
                  cin   <= op_sub;
                  cnt   <= '0;
                  r_reg <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               cin <= sum[M];
               if (last) begin
                  r_reg <= r_fin;
                  c_q   <= sum[M];
                  n_q   <= n_fin;
                  v_q   <= v_fin;
                  z_q   <= z_fin;
                  state <= S_DONE;
               end else begin
                  r_reg <= r_slice;
                  cnt   <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign start_ready = (state == S_IDLE);
   assign res_valid   = (state == S_DONE);
   assign busy        = (state != S_IDLE);
   assign R           = r_reg;
   assign C           = c_q;
   assign N           = n_q;
   assign V           = v_q;
   assign Z           = z_q;

endmodule

// File: tb/tb_suma_multipalabra_ctrl.sv
module tb_suma_multipalabra_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic [15:0] A, B;
   logic        op_sub;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] R;
   logic        C, N, V, Z;
   logic        busy;

   // Second instance with a single slice (K=1, M=8)
   logic        sv1, sr1, os1, rv1, rr1, c1, n1, v1, z1, busy1;
   logic [7:0]  a1, b1, r1;

   typedef struct packed {
      logic [15:0] r;
      logic        c;
      logic        n;
      logic        v;
      logic        z;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   suma_multipalabra_ctrl #(.M(4), .K(4)) dut (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
      .A(A), .B(B), .op_sub(op_sub), .res_valid(res_valid), .res_ready(res_ready),
      .R(R), .C(C), .N(N), .V(V), .Z(Z), .busy(busy)
   );

   suma_multipalabra_ctrl #(.M(8), .K(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
      .A(a1), .B(b1), .op_sub(os1), .res_valid(rv1), .res_ready(rr1),
      .R(r1), .C(c1), .N(n1), .V(v1), .Z(z1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
      logic [15:0] bb;
      logic [16:0] t;
      exp_t e;
      bb  = s ? ~b : b;
      t   = {1'b0, a} + {1'b0, bb} + 17'(s);
      e.r = t[15:0];
      e.c = t[16];
      e.v = (a[15] == bb[15]) && (t[15] != a[15]);
`ifdef SUMA_CTRL_SAT_EN
      if (e.v) e.r = a[15] ? 16'h8000 : 16'h7FFF;
`endif
      e.n = e.r[15];
      e.z = (e.r == 16'h0000);
      return e;
   endfunction

   // Present an operation and return at the negedge right after the accept edge
   task automatic drive_accept(input logic [15:0] a, input logic [15:0] b, input logic s);
      int n = 0;
      while (!start_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", start_ready, 1);
      A = a; B = b; op_sub = s; start_valid = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag);
      int lat = 0;
      while (!res_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, 4);
   endtask

   task automatic check_result(input string tag, input exp_t e);
      chk({tag, "_R"}, R, e.r);
      chk({tag, "_C"}, C, e.c);
      chk({tag, "_N"}, N, e.n);
      chk({tag, "_V"}, V, e.v);
      chk({tag, "_Z"}, Z, e.z);
   endtask

   task automatic take_result(input string tag);
      exp_t e;
      chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_result(tag, e);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({tag, "_rv_low"}, res_valid, 0);
      chk({tag, "_sr_high"}, start_ready, 1);
      chk({tag, "_busy_low"}, busy, 0);
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s);
      drive_accept(a, b, s);
      sb.push_back(model(a, b, s));
      wait_result(tag);
      take_result(tag);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_rv"}, res_valid, 0);
      chk({tag, "_sr"}, start_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_R"}, R, 16'h0000);
      chk({tag, "_flags"}, {C, N, V, Z}, 4'b0000);
   endtask

   initial begin
      exp_t e;
      int   lat;

      rst_n = 1'b0; start_valid = 1'b0; A = '0; B = '0; op_sub = 1'b0; res_ready = 1'b0;
      sv1 = 1'b0; a1 = '0; b1 = '0; os1 = 1'b0; rr1 = 1'b0;

      // Reset values, during and after reset
      repeat (3) @(negedge clk);
      check_reset_state("rst_hold");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_state("rst_rel");

      // Reset two cycles into RUN aborts the operation without waiting for a clock edge
      drive_accept(16'hFFFF, 16'h0001, 1'b0);
      repeat (2) @(negedge clk);
      chk("midrun_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset_state("rst_midrun");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_state("rst_midrun_rel");

      // Directed arithmetic
      run_op("add_ff_1",   16'h00FF, 16'h0001, 1'b0);
      run_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0);
      run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0);
      run_op("add_novf",   16'h8000, 16'hFFFF, 1'b0);
      run_op("sub_5_7",    16'h0005, 16'h0007, 1'b1);
      run_op("sub_7_5",    16'h0007, 16'h0005, 1'b1);
      run_op("sub_zero",   16'h1234, 16'h1234, 1'b1);
      run_op("sub_ovf",    16'h8000, 16'h0001, 1'b1);
      for (int i = 0; i < 6; i++) begin
         run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom));
      end

      // Backpressure: result held stable while inputs keep changing
      drive_accept(16'h1234, 16'h1111, 1'b0);
      sb.push_back(model(16'h1234, 16'h1111, 1'b0));
      wait_result("bp");
      e = sb.pop_front();
      for (int i = 0; i < 10; i++) begin
         start_valid = ~start_valid;
         A = 16'($urandom);
         @(negedge clk);
         check_result("bp_hold", e);
         chk("bp_rv", res_valid, 1);
         chk("bp_sr", start_ready, 0);
      end
      start_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("bp_rel_rv", res_valid, 0);
      chk("bp_rel_sr", start_ready, 1);
      check_result("bp_keep", e);
      @(negedge clk);
      chk("bp_noqueue_busy", busy, 0);
      chk("bp_noqueue_sr", start_ready, 1);

      // Single-slice instance: 0x30 + 0x45 = 0x75, done one edge after accept
      a1 = 8'h30; b1 = 8'h45; os1 = 1'b0; sv1 = 1'b1;
      @(negedge clk);
      sv1 = 1'b0;
      lat = 0;
      while (!rv1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("k1_latency", lat, 1);
      chk("k1_R", r1, 8'h75);
      chk("k1_flags", {c1, n1, v1, z1}, 4'b0000);
      rr1 = 1'b1;
      @(negedge clk);
      rr1 = 1'b0;
      chk("k1_rv_low", rv1, 0);
      chk("k1_sr_high", sr1, 1);

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
